board_state_controller: RTL and testbench



---
 rtl/board_state_controller_if.sv | 28 ++
 rtl/board_state_controller.sv | 145 ++++++++++++++
 tb/tb_board_state_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_state_controller_if.sv
// Drop-request and game-state bundle between the column calculator side (master)
// and the board state controller (slave).
interface board_state_controller_if;
    logic        new_game;
    logic        drop_valid;
    logic [4:0]  drop_position;
    logic [11:0] counters;
    logic [15:0] board_occupied;
    logic [15:0] board_player;
    logic        current_player;
    logic        busy;
    logic        drop_ack;
    logic        drop_reject;
    logic [1:0]  winner;
    logic        game_over;

    modport master (
        output new_game, drop_valid, drop_position,
        input  counters, board_occupied, board_player, current_player,
               busy, drop_ack, drop_reject, winner, game_over
    );

    modport slave (
        input  new_game, drop_valid, drop_position,
        output counters, board_occupied, board_player, current_player,
               busy, drop_ack, drop_reject, winner, game_over
    );
endinterface

// File: rtl/board_state_controller.sv
// 4x4 Connect-4 game-state keeper: accepts drops, tracks column fill, detects win/draw.
// Define CONNECT4_DIAG_WIN_EN to also count the two long diagonals as win lines.
module board_state_controller (
    input  logic                     clk,
    input  logic                     reset,
    board_state_controller_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLACE, S_CHECK, S_OVER} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_drop_valid_q;
    logic [3:0]  r_pos, w_pos_nxt;
    logic [11:0] r_counters, w_counters_nxt;
    logic [15:0] r_occ, w_occ_nxt;
    logic [15:0] r_player, w_player_nxt;
    logic        r_cur, w_cur_nxt;
    logic        r_ack, w_ack_nxt;
    logic        r_reject, w_reject_nxt;
    logic [1:0]  r_winner, w_winner_nxt;
    logic        r_game_over, w_game_over_nxt;

    logic        w_edge;
    logic        w_req_ok;
    logic        w_win;
    logic [2:0]  w_col_cnt;
    logic [15:0] w_mine;

    assign w_edge = bus.drop_valid & ~r_drop_valid_q;
    assign w_mine = r_occ & (r_cur ? r_player : ~r_player);

    always_comb begin
        w_col_cnt = 3'd0;
        for (int c = 0; c < 4; c++)
            if (bus.drop_position[1:0] == 2'(c)) w_col_cnt = r_counters[3*c +: 3];
    end

    // Positions 16..30 name no cell; rejecting them also keeps a full column from matching row 4.
    assign w_req_ok = ~bus.drop_position[4]
                    & ~r_occ[bus.drop_position[3:0]]
                    & (w_col_cnt == {1'b0, bus.drop_position[3:2]});

    always_comb begin
        w_win = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (&w_mine[4*i +: 4]) w_win = 1'b1;
            if (w_mine[i] & w_mine[i+4] & w_mine[i+8] & w_mine[i+12]) w_win = 1'b1;
        end
`ifdef CONNECT4_DIAG_WIN_EN
        if (w_mine[0] & w_mine[5] & w_mine[10] & w_mine[15]) w_win = 1'b1;
        if (w_mine[3] & w_mine[6] & w_mine[9]  & w_mine[12]) w_win = 1'b1;
`endif
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_counters_nxt  = r_counters;
        w_occ_nxt       = r_occ;
        w_player_nxt    = r_player;
        w_cur_nxt       = r_cur;
        w_ack_nxt       = 1'b0;
        w_reject_nxt    = 1'b0;
        w_winner_nxt    = r_winner;
        w_game_over_nxt = r_game_over;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    if (w_req_ok) begin
                        w_pos_nxt   = bus.drop_position[3:0];
                        w_state_nxt = S_PLACE;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            S_PLACE: begin
                w_occ_nxt[r_pos]    = 1'b1;
                w_player_nxt[r_pos] = r_cur;
                for (int c = 0; c < 4; c++)
                    if (r_pos[1:0] == 2'(c))
                        w_counters_nxt[3*c +: 3] = r_counters[3*c +: 3] + 3'd1;
                w_ack_nxt   = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_win) begin
                    w_winner_nxt    = {r_cur, ~r_cur};
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_OVER;
                end else if (&r_occ) begin
                    w_winner_nxt    = 2'b11;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_OVER;
                end else begin
                    w_cur_nxt   = ~r_cur;
                    w_state_nxt = S_IDLE;
                end
            end
            S_OVER: begin
                if (w_edge) w_reject_nxt = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset || bus.new_game) begin
            r_state        <= S_IDLE;
            r_drop_valid_q <= 1'b0;
            r_pos          <= 4'd0;
            r_counters     <= 12'd0;
            r_occ          <= 16'd0;
            r_player       <= 16'd0;
            r_cur          <= 1'b0;
            r_ack          <= 1'b0;
            r_reject       <= 1'b0;
            r_winner       <= 2'b00;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_drop_valid_q <= bus.drop_valid;
            r_pos          <= w_pos_nxt;
            r_counters     <= w_counters_nxt;
            r_occ          <= w_occ_nxt;
            r_player       <= w_player_nxt;
            r_cur          <= w_cur_nxt;
            r_ack          <= w_ack_nxt;
            r_reject       <= w_reject_nxt;
            r_winner       <= w_winner_nxt;
            r_game_over    <= w_game_over_nxt;
        end
    end

    assign bus.counters       = r_counters;
    assign bus.board_occupied = r_occ;
    assign bus.board_player   = r_player;
    assign bus.current_player = r_cur;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.drop_ack       = r_ack;
    assign bus.drop_reject    = r_reject;
    assign bus.winner         = r_winner;
    assign bus.game_over      = r_game_over;
endmodule

// File: tb/tb_board_state_controller.sv
// Self-checking bench for board_state_controller: directed game scenarios plus random play,
// compared against a cell-ownership model of the game rules.
module tb_board_state_controller;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    board_state_controller_if bus();

    board_state_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Game model: owner 0 = empty, 1 = player 1, 2 = player 2.
    int owner [16];
    int m_cur;
    int m_winner;
    bit m_over;
    int lines [10][4];
    int n_lines;

    int seq_row  [7]  = '{0, 4, 1, 5, 2, 6, 3};
    int seq_diag [11] = '{0, 1, 5, 2, 3, 6, 10, 7, 11, 4, 15};
    int seq_draw [16] = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int height(input int c);
        int h = 0;
        for (int r = 0; r < 4; r++) if (owner[c + 4*r] != 0) h++;
        return h;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) owner[i] = 0;
        m_cur = 0; m_winner = 0; m_over = 1'b0;
    endfunction

    function automatic bit model_legal(input int pos);
        if (m_over || pos > 15) return 1'b0;
        if (owner[pos] != 0) return 1'b0;
        return height(pos % 4) == pos / 4;
    endfunction

    function automatic void model_place(input int pos);
        owner[pos] = m_cur + 1;
    endfunction

    function automatic void model_resolve();
        bit won = 1'b0;
        bit full = 1'b1;
        for (int l = 0; l < n_lines; l++) begin
            bit all = 1'b1;
            for (int k = 0; k < 4; k++) if (owner[lines[l][k]] != m_cur + 1) all = 1'b0;
            if (all) won = 1'b1;
        end
        for (int i = 0; i < 16; i++) if (owner[i] == 0) full = 1'b0;
        if (won) begin
            m_winner = m_cur + 1; m_over = 1'b1;
        end else if (full) begin
            m_winner = 3; m_over = 1'b1;
        end else begin
            m_cur = 1 - m_cur;
        end
    endfunction

    function automatic logic [15:0] exp_occ();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = (owner[i] != 0);
        return v;
    endfunction

    function automatic logic [15:0] exp_player();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = (owner[i] == 2);
        return v;
    endfunction

    function automatic logic [11:0] exp_counters();
        logic [11:0] v = '0;
        for (int c = 0; c < 4; c++) v[3*c +: 3] = 3'(height(c));
        return v;
    endfunction

    task automatic check_board(input string tag);
        check({tag, "_occupied"}, bus.board_occupied, exp_occ());
        check({tag, "_player"},   bus.board_player,   exp_player());
        check({tag, "_counters"}, bus.counters,       exp_counters());
        check({tag, "_cur"},      bus.current_player, m_cur);
        check({tag, "_winner"},   bus.winner,         m_winner);
        check({tag, "_over"},     bus.game_over,      m_over);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_occupied"}, bus.board_occupied, 0);
        check({tag, "_player"},   bus.board_player,   0);
        check({tag, "_counters"}, bus.counters,       0);
        check({tag, "_cur"},      bus.current_player, 0);
        check({tag, "_winner"},   bus.winner,         0);
        check({tag, "_over"},     bus.game_over,      0);
        check({tag, "_busy"},     bus.busy,           0);
        check({tag, "_ack"},      bus.drop_ack,       0);
        check({tag, "_reject"},   bus.drop_reject,    0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        check_cleared("reset");
        reset = 1'b0;
    endtask

    // One request edge, then follow it to completion (accept: 3 cycles, reject: 2 cycles).
    task automatic drop(input int pos);
        bit ok = model_legal(pos);
        bus.drop_valid    = 1'b1;
        bus.drop_position = 5'(pos);
        @(negedge clk);
        bus.drop_valid = 1'b0;
        if (ok) begin
            check("accept_busy", bus.busy, 1);
            check("accept_no_early_ack", bus.drop_ack, 0);
            model_place(pos);
            @(negedge clk);
            check("drop_ack", bus.drop_ack, 1);
            check_board("place");
            model_resolve();
            @(negedge clk);
            check("ack_one_cycle", bus.drop_ack, 0);
            check_board("resolve");
            check("busy_after_check", bus.busy, m_over);
        end else begin
            check("drop_reject", bus.drop_reject, 1);
            check("reject_no_ack", bus.drop_ack, 0);
            @(negedge clk);
            check("reject_one_cycle", bus.drop_reject, 0);
            check_board("reject");
        end
    endtask

    initial begin
        n_lines = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) lines[n_lines][k] = 4*i + k;
            n_lines++;
            for (int k = 0; k < 4; k++) lines[n_lines][k] = i + 4*k;
            n_lines++;
        end
`ifdef CONNECT4_DIAG_WIN_EN
        lines[n_lines] = '{0, 5, 10, 15}; n_lines++;
        lines[n_lines] = '{3, 6, 9, 12};  n_lines++;
`endif
        bus.new_game      = 1'b0;
        bus.drop_valid    = 1'b0;
        bus.drop_position = 5'h1f;
        @(negedge clk);
        do_reset();

        // First drop at the bottom-left corner.
        drop(0);
        check("first_occupied", bus.board_occupied, 16'h0001);
        check("first_counters", bus.counters, 12'h001);
        check("first_cur", bus.current_player, 1);

        // Request held high for 10 cycles fires once.
        begin
            int acks = 0;
            int rejs = 0;
            bus.drop_valid    = 1'b1;
            bus.drop_position = 5'd1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.drop_ack) acks++;
                if (bus.drop_reject) rejs++;
            end
            bus.drop_valid = 1'b0;
            model_place(1);
            model_resolve();
            @(negedge clk);
            check("held_ack_count", acks, 1);
            check("held_reject_count", rejs, 0);
            check("held_col1_count", bus.counters[5:3], 1);
            check_board("held");
        end

        // Floating cell and the 'none' code are both refused.
        do_reset();
        drop(4);
        drop(31);
        check("rejects_board_empty", bus.board_occupied, 0);

        // Bottom-row win for player 1, then a refused edge in OVER.
        do_reset();
        foreach (seq_row[i]) drop(seq_row[i]);
        check("row_win_winner", bus.winner, 2'b01);
        check("row_win_over", bus.game_over, 1);
        drop(7);
        drop(8);

        // Diagonal {0,5,10,15} owned by player 1.
        do_reset();
        foreach (seq_diag[i]) drop(seq_diag[i]);
`ifdef CONNECT4_DIAG_WIN_EN
        check("diag_winner", bus.winner, 2'b01);
`else
        check("diag_winner", bus.winner, 2'b00);
        check("diag_continues", bus.current_player, 1);
`endif

        // Full board with no line of four.
        do_reset();
        foreach (seq_draw[i]) drop(seq_draw[i]);
        check("draw_winner", bus.winner, 2'b11);
        drop(0);

        // new_game while the FSM sits in CHECK.
        do_reset();
        drop(0);
        bus.drop_valid    = 1'b1;
        bus.drop_position = 5'd1;
        @(negedge clk);
        bus.drop_valid = 1'b0;
        @(negedge clk);
        check("pre_abort_ack", bus.drop_ack, 1);
        bus.new_game = 1'b1;
        @(negedge clk);
        check_cleared("abort");
        bus.new_game = 1'b0;
        model_clear();
        drop(0);

        // Random games, mostly on legal columns, some junk positions.
        for (int g = 0; g < 4; g++) begin
            bus.new_game = 1'b1;
            @(negedge clk);
            bus.new_game = 1'b0;
            model_clear();
            check_cleared("rand_new_game");
            for (int d = 0; d < 30; d++) begin
                int pos;
                if ($urandom_range(0, 3) != 0) begin
                    int c = $urandom_range(0, 3);
                    pos = 4*height(c) + c;
                end else if ($urandom_range(0, 1) == 0) begin
                    pos = 31;
                end else begin
                    pos = $urandom_range(0, 19);
                end
                drop(pos);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
